// File: rtl/wiper_pkg.sv
// Shared types and constants for the wiper motor sequencer.
//   speed_t  : speed request / effective demand encoding
//   wstate_t : sequencer FSM states
package wiper_pkg;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2,
    SPD_INT  = 2'd3
  } speed_t;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OUT   = 2'd1,
    BACK  = 2'd2,
    DWELL = 2'd3
  } wstate_t;

  localparam int unsigned WIPE_CNT_BITS = 8;

endpackage

// File: rtl/wiper_step_timer.sv
// Position step divider for the wiper sequencer.
// The tick counts 0..div-1; step is asserted while tick >= div-1, so a
// divisor shortened mid-count steps immediately instead of wrapping.
// Ports:
//   clk_2  in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   hold tick at 0 (blade not moving)
//   div    in   clocks per position step, must be >= 1
//   step   out  advance blade position this clock
module wiper_step_timer
  import wiper_pkg::*;
#(
  parameter int TICK_W = 3
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              clear,
  input  logic [TICK_W-1:0] div,
  output logic              step
);

  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_last;

  assign w_last = div - 1'b1;
  assign step   = (r_tick >= w_last);

  always_ff @(posedge clk_2) begin
    if (reset || clear || step) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

endmodule

// File: rtl/wiper_sequencer.sv
// Windshield wiper motor sequencer.
// Runs full sweep cycles (park -> far end -> park) at the effective speed,
// always returns the blade to park before stopping, latches manual single
// wipes and sequences the washer pump with follow-up wipes.
// Optional build macro: INTERMITTENT_EN adds a DWELL state between
// intermittent wipes (speed_req = 3); without it code 3 runs as slow.
// Ports:
//   clk_2        in   system clock
//   reset        in   synchronous active-high reset
//   speed_req    in   0 off, 1 slow, 2 fast, 3 intermittent
//   single_wipe  in   one-clock pulse requesting one slow cycle
//   wash_req     in   washer button level
//   motor_on     out  motor energised
//   motor_fast   out  fast winding selected (meaningful with motor_on)
//   pump_on      out  washer pump energised
//   parked       out  blade resting at position 0
//   pos          out  blade position
//   wipe_count   out  completed cycles, wrapping
module wiper_sequencer
  import wiper_pkg::*;
#(
  parameter int SWEEP_LEN   = 8,
  parameter int SLOW_DIV    = 4,
  parameter int FAST_DIV    = 2,
  parameter int AFTER_WIPES = 2,
  parameter int DWELL_CYC   = 16
) (
  input  logic                         clk_2,
  input  logic                         reset,
  input  logic [1:0]                   speed_req,
  input  logic                         single_wipe,
  input  logic                         wash_req,
  output logic                         motor_on,
  output logic                         motor_fast,
  output logic                         pump_on,
  output logic                         parked,
  output logic [$clog2(SWEEP_LEN)-1:0] pos,
  output logic [WIPE_CNT_BITS-1:0]     wipe_count
);

  localparam int POS_W   = $clog2(SWEEP_LEN);
  localparam int TICK_W  = $clog2(SLOW_DIV + 1);
  localparam int AFTER_W = $clog2(AFTER_WIPES + 2);
  localparam logic [POS_W-1:0] LAST = POS_W'(SWEEP_LEN - 1);

  if (SWEEP_LEN < 2 || FAST_DIV < 1 || FAST_DIV >= SLOW_DIV || DWELL_CYC < 1)
  begin : g_bad_param
    $error("wiper_sequencer: illegal parameter combination");
  end

  wstate_t                  r_state;
  logic [POS_W-1:0]         r_pos;
  logic                     r_motor_on;
  logic                     r_motor_fast;
  logic                     r_pump_on;
  logic                     r_parked;
  logic [WIPE_CNT_BITS-1:0] r_wipe_count;
  logic [AFTER_W-1:0]       r_after_cnt;
  logic                     r_sw_latch;

  speed_t                   w_speed;
  speed_t                   w_demand;
  logic                     w_wash_dmd;
  logic                     w_cont;
  logic                     w_moving;
  logic                     w_moving_d;
  logic                     w_step;
  logic                     w_done;
  logic [TICK_W-1:0]        w_div;
  wstate_t                  w_state_d;
  logic [POS_W-1:0]         w_pos_d;

`ifdef INTERMITTENT_EN
  localparam int DW_W = $clog2(DWELL_CYC + 1);
  logic [DW_W-1:0] r_dwell_cnt;
`endif

  assign w_speed = speed_t'(speed_req);

  // Effective demand, highest priority first.
  always_comb begin
    w_wash_dmd = r_pump_on || (r_after_cnt != '0);
    if (w_wash_dmd) begin
      w_demand = SPD_SLOW;
    end else if (w_speed == SPD_FAST) begin
      w_demand = SPD_FAST;
    end else if (w_speed != SPD_OFF) begin
      w_demand = SPD_SLOW;
    end else if (r_sw_latch) begin
      w_demand = SPD_SLOW;
    end else begin
      w_demand = SPD_OFF;
    end
    // At cycle completion the latch is consumed by that cycle, so only a
    // fresh pulse in the same clock keeps the motor going. The after-wipe
    // count is tested before its decrement so it yields that many extra cycles.
    w_cont = w_wash_dmd || (w_speed != SPD_OFF) || single_wipe;
  end

  assign w_moving = (r_state == OUT) || (r_state == BACK);
  assign w_div    = (w_demand == SPD_FAST) ? TICK_W'(FAST_DIV) : TICK_W'(SLOW_DIV);

  wiper_step_timer #(
    .TICK_W (TICK_W)
  ) u_step_timer (
    .clk_2 (clk_2),
    .reset (reset),
    .clear (!w_moving),
    .div   (w_div),
    .step  (w_step)
  );

  always_comb begin
    w_state_d = r_state;
    w_pos_d   = r_pos;
    w_done    = 1'b0;
    case (r_state)
      PARK: begin
        if (w_demand != SPD_OFF) w_state_d = OUT;
      end
      OUT, BACK: begin
        if (w_step) begin
          if (r_state == OUT && r_pos != LAST) begin
            w_pos_d = r_pos + 1'b1;
          end else begin
            // Step off the far end (or continue the return stroke).
            w_pos_d   = r_pos - 1'b1;
            w_state_d = BACK;
            if (r_pos == POS_W'(1)) begin
              w_done    = 1'b1;
              w_state_d = w_cont ? OUT : PARK;
`ifdef INTERMITTENT_EN
              if (!w_wash_dmd && w_speed == SPD_INT) w_state_d = DWELL;
`endif
            end
          end
        end
      end
      DWELL: begin
`ifdef INTERMITTENT_EN
        if (w_speed == SPD_OFF) begin
          w_state_d = (w_demand != SPD_OFF) ? OUT : PARK;
        end else if (w_wash_dmd || w_speed != SPD_INT) begin
          w_state_d = OUT;
        end else if (r_dwell_cnt == DW_W'(DWELL_CYC - 1)) begin
          w_state_d = OUT;
        end
`else
        w_state_d = PARK;
`endif
      end
      default: w_state_d = PARK;
    endcase
  end

  assign w_moving_d = (w_state_d == OUT) || (w_state_d == BACK);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state      <= PARK;
      r_pos        <= '0;
      r_motor_on   <= 1'b0;
      r_motor_fast <= 1'b0;
      r_pump_on    <= 1'b0;
      r_parked     <= 1'b1;
      r_wipe_count <= '0;
      r_after_cnt  <= '0;
      r_sw_latch   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_pos        <= w_pos_d;
      r_motor_on   <= w_moving_d;
      r_motor_fast <= w_moving_d && (w_demand == SPD_FAST);
      r_parked     <= (w_state_d == PARK) || (w_state_d == DWELL);
      r_pump_on    <= wash_req;

      if (w_done) r_wipe_count <= r_wipe_count + 1'b1;

      // A pulse coincident with completion re-arms after the clear.
      if (w_done) begin
        r_sw_latch <= single_wipe;
      end else if (single_wipe) begin
        r_sw_latch <= 1'b1;
      end

      if (r_pump_on && !wash_req) begin
        r_after_cnt <= AFTER_W'(AFTER_WIPES);
      end else if (wash_req) begin
        r_after_cnt <= '0;
      end else if (w_done && r_after_cnt != '0) begin
        r_after_cnt <= r_after_cnt - 1'b1;
      end
    end
  end

`ifdef INTERMITTENT_EN
  always_ff @(posedge clk_2) begin
    if (reset || r_state != DWELL) begin
      r_dwell_cnt <= '0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + 1'b1;
    end
  end
`endif

  assign motor_on   = r_motor_on;
  assign motor_fast = r_motor_fast;
  assign pump_on    = r_pump_on;
  assign parked     = r_parked;
  assign pos        = r_pos;
  assign wipe_count = r_wipe_count;

endmodule

// File: tb/tb_wiper_sequencer.sv
// Directed testbench for wiper_sequencer with default parameters
// (SWEEP_LEN 8, SLOW_DIV 4, FAST_DIV 2, AFTER_WIPES 2, DWELL_CYC 16).
// Edge numbering: E0 is the first clock edge that samples a new request.
module tb_wiper_sequencer;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] speed_req;
  logic       single_wipe;
  logic       wash_req;
  logic       motor_on;
  logic       motor_fast;
  logic       pump_on;
  logic       parked;
  logic [2:0] pos;
  logic [7:0] wipe_count;

  int n_checks = 0;
  int n_pass   = 0;

  wiper_sequencer u_dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .speed_req   (speed_req),
    .single_wipe (single_wipe),
    .wash_req    (wash_req),
    .motor_on    (motor_on),
    .motor_fast  (motor_fast),
    .pump_on     (pump_on),
    .parked      (parked),
    .pos         (pos),
    .wipe_count  (wipe_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset       = 1'b1;
    speed_req   = 2'd0;
    single_wipe = 1'b0;
    wash_req    = 1'b0;
    run(2);
    check("rst_parked", parked, 1);
    check("rst_motor", motor_on, 0);
    check("rst_fast", motor_fast, 0);
    check("rst_pump", pump_on, 0);
    check("rst_pos", pos, 0);
    check("rst_count", wipe_count, 0);
    reset = 1'b0;
    run(2);

    // Slow request for one clock: exactly one full cycle.
    speed_req = 2'd1;
    tick();                                   // E0
    speed_req = 2'd0;
    check("s1_motor_on", motor_on, 1);
    check("s1_fast", motor_fast, 0);
    check("s1_parked", parked, 0);
    run(27);                                  // E27
    check("s1_pos6", pos, 6);
    tick();                                   // E28
    check("s1_pos7", pos, 7);
    run(27);                                  // E55
    check("s1_pos1", pos, 1);
    check("s1_cnt_before", wipe_count, 0);
    tick();                                   // E56
    check("s1_cnt", wipe_count, 1);
    check("s1_parked_end", parked, 1);
    check("s1_motor_off", motor_on, 0);
    run(20);
    check("s1_no_second", wipe_count, 1);

    // Fast held: step every 2 clocks, cycle every 28 clocks.
    speed_req = 2'd2;
    tick();                                   // F0
    check("f_motor_on", motor_on, 1);
    check("f_fast", motor_fast, 1);
    run(2);                                   // F2
    check("f_pos1", pos, 1);
    run(26);                                  // F28
    check("f_cnt2", wipe_count, 2);
    check("f_pos0", pos, 0);
    check("f_still_on", motor_on, 1);
    run(28);                                  // F56
    check("f_cnt3", wipe_count, 3);
    // Stop at pos 0 mid-run: one more cycle at slow divide, then park.
    speed_req = 2'd0;
    tick();                                   // F57
    check("f_stop_slowwind", motor_fast, 0);
    check("f_stop_on", motor_on, 1);
    run(54);                                  // F111
    check("f_stop_pos1", pos, 1);
    tick();                                   // F112
    check("f_stop_parked", parked, 1);
    check("f_stop_cnt", wipe_count, 4);

    // Stop requested at pos 3 on the outward stroke.
    speed_req = 2'd1;
    tick();                                   // G0
    run(12);                                  // G12
    check("m_pos3", pos, 3);
    speed_req = 2'd0;
    run(16);                                  // G28
    check("m_far_end", pos, 7);
    check("m_on", motor_on, 1);
    run(28);                                  // G56
    check("m_parked", parked, 1);
    check("m_cnt", wipe_count, 5);
    run(20);
    check("m_cnt_hold", wipe_count, 5);

    // Single wipe: second pulse ignored, third at completion runs one more.
    single_wipe = 1'b1;
    tick();                                   // S0
    single_wipe = 1'b0;
    check("sw_latch_only", motor_on, 0);
    tick();                                   // S1
    check("sw_start", motor_on, 1);
    run(19);                                  // S20
    single_wipe = 1'b1;
    tick();                                   // S21
    single_wipe = 1'b0;
    run(35);                                  // S56
    check("sw_pos1", pos, 1);
    check("sw_cnt_before", wipe_count, 5);
    single_wipe = 1'b1;
    tick();                                   // S57
    single_wipe = 1'b0;
    check("sw_cnt6", wipe_count, 6);
    check("sw_continue", motor_on, 1);
    run(56);                                  // S113
    check("sw_cnt7", wipe_count, 7);
    check("sw_parked", parked, 1);
    run(60);
    check("sw_no_third", wipe_count, 7);

    // Washer held 10 clocks: current cycle plus two follow-up cycles.
    wash_req = 1'b1;
    tick();                                   // W0
    check("w_pump_on", pump_on, 1);
    check("w_motor_late", motor_on, 0);
    run(9);                                   // W9
    check("w_pump_held", pump_on, 1);
    check("w_motor_on", motor_on, 1);
    check("w_slow", motor_fast, 0);
    wash_req = 1'b0;
    tick();                                   // W10
    check("w_pump_off", pump_on, 0);
    run(158);                                 // W168
    check("w_cnt9", wipe_count, 9);
    check("w_on_last", motor_on, 1);
    tick();                                   // W169
    check("w_cnt10", wipe_count, 10);
    check("w_parked", parked, 1);
    run(60);
    check("w_cnt_hold", wipe_count, 10);

    // Reset during the return stroke.
    speed_req = 2'd1;
    tick();                                   // R0
    run(36);                                  // R36
    check("r_pos5", pos, 5);
    check("r_moving", motor_on, 1);
    reset     = 1'b1;
    speed_req = 2'd0;
    tick();
    check("r_pos0", pos, 0);
    check("r_parked", parked, 1);
    check("r_motor", motor_on, 0);
    check("r_cnt", wipe_count, 0);
    reset = 1'b0;
    tick();

    // Slow to fast with tick already past the new limit: immediate step.
    speed_req = 2'd1;
    tick();                                   // H0
    run(2);                                   // H2
    check("h_pos0", pos, 0);
    speed_req = 2'd2;
    tick();                                   // H3
    check("h_early_step", pos, 1);
    check("h_fast", motor_fast, 1);
    run(2);                                   // H5
    check("h_pos2", pos, 2);
    reset     = 1'b1;
    speed_req = 2'd0;
    tick();
    reset = 1'b0;
    tick();

`ifdef INTERMITTENT_EN
    // Intermittent: 16-clock dwell parked between cycles.
    speed_req = 2'd3;
    tick();                                   // I0
    check("i_start", motor_on, 1);
    run(56);                                  // I56
    check("i_cnt1", wipe_count, 1);
    check("i_dwell_off", motor_on, 0);
    check("i_dwell_parked", parked, 1);
    run(15);                                  // I71
    check("i_still_dwell", motor_on, 0);
    tick();                                   // I72
    check("i_restart", motor_on, 1);
    speed_req = 2'd0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wiper_sequencer.md
Name: wiper_sequencer

Overview:
Motor sequencer for the windshield wiper. It takes the speed decision from the rain-sensing logic (off/slow/fast), a manual single-wipe pulse and a washer request. It drives the wiper motor through full sweep cycles and tracks blade position with an internal step counter. It guarantees the blade always comes to rest at park, and it sequences the washer pump with its follow-up wipes.

Parameters:
SWEEP_LEN, 8, blade positions per stroke (0 = park, SWEEP_LEN-1 = far end); must be >= 2
SLOW_DIV, 4, clocks per position step at slow speed; must be >= 1
FAST_DIV, 2, clocks per position step at fast speed; must be >= 1, < SLOW_DIV
AFTER_WIPES, 2, full wipe cycles run after wash_req deasserts
DWELL_CYC, 16, park dwell in clocks between intermittent wipes (INTERMITTENT_EN only)

Ports:
clk_2  in  1  system clock
reset  in  1  synchronous, active-high reset
speed_req  in  2  requested speed: 0 off, 1 slow, 2 fast, 3 intermittent
single_wipe  in  1  one-clock pulse requesting one slow wipe cycle
wash_req  in  1  level, washer button held
motor_on  out  1  motor energised
motor_fast  out  1  motor in fast winding (valid only while motor_on)
pump_on  out  1  washer pump energised
parked  out  1  blade at position 0 in PARK state
pos  out  $clog2(SWEEP_LEN)  current blade position
wipe_count  out  8  completed full cycles, wraps 255->0

Behaviour:
- Interface: one clock, clk_2. Reset is synchronous and active-high on port reset.
- Reset values: state PARK, pos 0, step tick 0, motor_on 0, motor_fast 0, pump_on 0, parked 1, wipe_count 0, after-wipe counter 0, single-wipe latch 0.
- States: PARK, OUT (pos increments), BACK (pos decrements), DWELL (INTERMITTENT_EN only).
- All outputs are registered and reflect the current state and pos.
- Step tick:
  - Counts 0..div-1 and clears on entering OUT from PARK or DWELL.
  - pos steps when tick == div-1, then tick returns to 0.
  - div is FAST_DIV when the effective speed is fast, otherwise SLOW_DIV.
  - div is re-evaluated every clock, so a speed change mid-stroke takes effect at the next step.
  - If tick >= new div-1 after a change, the step happens immediately.
- Effective demand, in priority order:
  1. pump_on = 1 or after-wipe counter != 0: slow.
  2. speed_req fast: fast.
  3. speed_req slow or intermittent: slow.
  4. Pending single-wipe latch: slow.
  5. Otherwise: none.
- PARK -> OUT on the next clock when demand != none. Then motor_on = 1 and motor_fast = (demand == fast).
- OUT: when pos reaches SWEEP_LEN-1, the next step moves to BACK, so the far end is held for one step period.
- BACK: when pos reaches 0, the cycle completes in that same clock:
  - wipe_count increments.
  - The single-wipe latch clears.
  - The after-wipe counter decrements if nonzero.
  - Next state is OUT if demand != none, otherwise PARK.
- A full cycle takes 2*(SWEEP_LEN-1) steps.
- Stop (demand none) mid-cycle: finish the current stroke and return to 0, then PARK. The blade never stops outside pos 0.
- single_wipe:
  - Sets the latch in any state. Pulses while the latch is set are ignored.
  - A pulse arriving in the same clock as a cycle completion sets the latch after the clear, so one more cycle runs.
- Washer:
  - pump_on = wash_req, registered with 1 clock latency.
  - On pump_on falling, the after-wipe counter loads AFTER_WIPES.
  - If wash_req re-asserts, the counter clears and reloads on the next release.
- Intermittent code 3 without INTERMITTENT_EN: treated as slow.

Optional Feature:
INTERMITTENT_EN
- Defined:
  - With speed_req = 3 and no higher-priority demand, a cycle completing at pos 0 enters DWELL. In DWELL, motor_on = 0 and parked = 1.
  - DWELL lasts DWELL_CYC clocks, then goes to OUT.
  - Any demand above intermittent exits DWELL to OUT on the next clock.
  - speed_req changing to off exits DWELL to PARK.
- Undefined: no DWELL state; code 3 behaves as slow.

Decomposition:
- Package wiper_pkg:
  - speed_t enum {SPD_OFF, SPD_SLOW, SPD_FAST, SPD_INT}.
  - wstate_t enum {PARK, OUT, BACK, DWELL}.
  - Constant WIPE_CNT_BITS = 8.
- Sub-module wiper_step_timer: the tick divider. Inputs clk_2, reset, clear, div. Output step.

Test Plan:
- SWEEP_LEN=8, SLOW_DIV=4, speed_req=1 for 1 cycle, then 0 -> motor_on rises next clock; pos 7 reached after 28 steps' clocks; wipe_count=1 and parked=1 at clock 57 after request; no second cycle.
- speed_req=2 held -> motor_fast=1, steps every 2 clocks; wipe_count increments every 28 clocks.
- speed_req=1, then set to 0 when pos=3 in OUT -> pos continues to 7 and back to 0, then PARK; wipe_count +1 only.
- single_wipe pulse with speed 0; second pulse mid-cycle; third pulse at the completion clock -> exactly 2 cycles total; second pulse ignored.
- wash_req held 10 clocks -> pump_on high for 10 clocks, 1 clock late; wiper slow; after release, current cycle plus 2 more cycles, then PARK.
- reset asserted with pos=5 in BACK -> next clock pos=0, parked=1, motor_on=0, wipe_count=0. With INTERMITTENT_EN and speed 3: PARK dwell of 16 clocks between cycles.
